// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - ROM/RAM req/ack bus between the sequencer and memories
interface cpu_sequencer_if;
  logic        rom_req;
  logic [15:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;
  logic        ram_req;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;
  logic [15:0] ram_rdata;

  modport master (
    output rom_req, rom_addr,
    input  rom_ack, rom_data,
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_ack, ram_rdata
  );

  modport slave (
    input  rom_req, rom_addr,
    output rom_ack, rom_data,
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_ack, ram_rdata
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/load/exec/store sequencer owning PC, A, D and the instruction register
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  cpu_sequencer_if.master        mem,
  output logic [15:0]            instr,
  output logic [15:0]            dat_a,
  output logic [15:0]            dat_d,
  output logic [15:0]            dat_dref_a,
  input  logic [15:0]            dat_r,
  input  logic                   a,
  input  logic                   d,
  input  logic                   dref_a,
  input  logic                   j,
  output logic [15:0]            dbg_pc,
  output logic                   busy_store
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_instr;
  logic [15:0] r_dref_a;
  logic [15:0] r_wdata;
  logic [15:0] r_st_addr;

  logic w_rom_xfer;
  logic w_ram_xfer;

  // Requests are gated by rst so acks during reset can never form a transfer.
  assign mem.rom_req   = !rst && (r_state == S_FETCH);
  assign mem.ram_req   = !rst && ((r_state == S_LOAD) || (r_state == S_STORE));
  assign mem.ram_we    = !rst && (r_state == S_STORE);
  assign mem.rom_addr  = r_pc;
  assign mem.ram_addr  = (r_state == S_STORE) ? r_st_addr : r_a;
  assign mem.ram_wdata = r_wdata;

  assign w_rom_xfer = mem.rom_req && mem.rom_ack;
  assign w_ram_xfer = mem.ram_req && mem.ram_ack;

  assign instr      = r_instr;
  assign dat_a      = r_a;
  assign dat_d      = r_d;
  assign dat_dref_a = r_dref_a;
  assign dbg_pc     = r_pc;
  assign busy_store = (r_state == S_STORE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_a       <= 16'h0000;
      r_d       <= 16'h0000;
      r_instr   <= 16'h0000;
      r_dref_a  <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_st_addr <= 16'h0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_rom_xfer) begin
            r_instr <= mem.rom_data;
            if (!mem.rom_data[15]) begin
              r_a  <= mem.rom_data;
              r_pc <= r_pc + 16'h0001;
            end else if (mem.rom_data[12]) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_LOAD: begin
          if (w_ram_xfer) begin
            r_dref_a <= mem.ram_rdata;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Every commit below reads the pre-EXEC value of r_a.
          if (a) r_a <= dat_r;
          if (d) r_d <= dat_r;
          r_pc <= j ? r_a : (r_pc + 16'h0001);
          if (dref_a) begin
            r_st_addr <= r_a;
            r_wdata   <= dat_r;
            r_state   <= S_STORE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_STORE: begin
          if (w_ram_xfer) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stores = 0;

  logic        rst, rst2;
  logic [15:0] instr, dat_a, dat_d, dat_dref_a, dat_r, dbg_pc;
  logic        a, d, dref_a, j, busy_store;
  logic [15:0] instr2, dat_a2, dat_d2, dat_dref_a2, dbg_pc2;
  logic        busy_store2;

  cpu_sequencer_if bus();
  cpu_sequencer_if bus2();

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .instr(instr), .dat_a(dat_a), .dat_d(dat_d), .dat_dref_a(dat_dref_a),
    .dat_r(dat_r), .a(a), .d(d), .dref_a(dref_a), .j(j),
    .dbg_pc(dbg_pc), .busy_store(busy_store)
  );

  cpu_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst2), .mem(bus2.master),
    .instr(instr2), .dat_a(dat_a2), .dat_d(dat_d2), .dat_dref_a(dat_dref_a2),
    .dat_r(16'h0000), .a(1'b0), .d(1'b0), .dref_a(1'b0), .j(1'b0),
    .dbg_pc(dbg_pc2), .busy_store(busy_store2)
  );

  always @(posedge clk)
    if (bus.ram_req && bus.ram_we && bus.ram_ack) n_stores <= n_stores + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.rom_ack = 1'b1; bus.rom_data = 16'h0000;
    bus.ram_ack = 1'b1; bus.ram_rdata = 16'h0000;
    bus2.rom_ack = 1'b0; bus2.rom_data = 16'h0000;
    bus2.ram_ack = 1'b0; bus2.ram_rdata = 16'h0000;
    dat_r = 16'h0000; a = 1'b0; d = 1'b0; dref_a = 1'b0; j = 1'b0;
    #1;
    check("rst_rom_req", {15'b0, bus.rom_req}, 16'h0000);
    check("rst_ram_req", {15'b0, bus.ram_req}, 16'h0000);
    tick(); tick();

    rst = 1'b0; bus.rom_ack = 1'b0; bus.ram_ack = 1'b0;
    #1;
    check("reset_pc", dbg_pc, 16'h0000);
    check("reset_a", dat_a, 16'h0000);
    check("reset_d", dat_d, 16'h0000);
    check("reset_instr", instr, 16'h0000);
    check("reset_rom_req", {15'b0, bus.rom_req}, 16'h0001);

    // data instruction, zero-wait
    bus.rom_ack = 1'b1; bus.rom_data = 16'h1234;
    tick();
    check("data_a", dat_a, 16'h1234);
    check("data_pc", dbg_pc, 16'h0001);
    check("data_rom_req", {15'b0, bus.rom_req}, 16'h0001);
    check("data_rom_addr", bus.rom_addr, 16'h0001);

    // ALU write to D with 3 ROM waits
    bus.rom_ack = 1'b0; bus.rom_data = 16'h8010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_rom_addr", bus.rom_addr, 16'h0001);
      check("wait_rom_req", {15'b0, bus.rom_req}, 16'h0001);
    end
    bus.rom_ack = 1'b1;
    tick();
    bus.rom_ack = 1'b0;
    dat_r = 16'h00FF; d = 1'b1;
    check("exec_instr", instr, 16'h8010);
    check("exec_rom_req", {15'b0, bus.rom_req}, 16'h0000);
    check("exec_ram_req", {15'b0, bus.ram_req}, 16'h0000);
    tick();
    d = 1'b0;
    check("alu_d", dat_d, 16'h00FF);
    check("alu_pc", dbg_pc, 16'h0002);
    check("alu_a_kept", dat_a, 16'h1234);
    check("alu_back_fetch", {15'b0, bus.rom_req}, 16'h0001);
    check("alu_no_ram", {15'b0, bus.ram_req}, 16'h0000);

    // *A load with 2 RAM waits
    bus.rom_ack = 1'b1; bus.rom_data = 16'h0040;
    tick();
    check("ld_set_a", dat_a, 16'h0040);
    bus.rom_data = 16'h9000;
    tick();
    bus.rom_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("ld_ram_req", {15'b0, bus.ram_req}, 16'h0001);
      check("ld_ram_we", {15'b0, bus.ram_we}, 16'h0000);
      check("ld_ram_addr", bus.ram_addr, 16'h0040);
      tick();
    end
    bus.ram_ack = 1'b1; bus.ram_rdata = 16'hBEEF;
    tick();
    bus.ram_ack = 1'b0;
    check("ld_dref", dat_dref_a, 16'hBEEF);
    check("ld_exec_ram_req", {15'b0, bus.ram_req}, 16'h0000);
    tick();
    check("ld_pc", dbg_pc, 16'h0004);

    // simultaneous a/dref_a/j
    bus.rom_ack = 1'b1; bus.rom_data = 16'h0010;
    tick();
    bus.rom_data = 16'h8000;
    tick();
    bus.rom_ack = 1'b0;
    dat_r = 16'h0777; a = 1'b1; dref_a = 1'b1; j = 1'b1;
    tick();
    a = 1'b0; dref_a = 1'b0; j = 1'b0;
    check("st_a", dat_a, 16'h0777);
    check("st_pc", dbg_pc, 16'h0010);
    check("st_busy", {15'b0, busy_store}, 16'h0001);
    check("st_ram_we", {15'b0, bus.ram_we}, 16'h0001);
    check("st_ram_addr", bus.ram_addr, 16'h0010);
    check("st_ram_wdata", bus.ram_wdata, 16'h0777);
    tick();
    check("st_hold_addr", bus.ram_addr, 16'h0010);
    bus.ram_ack = 1'b1;
    tick();
    bus.ram_ack = 1'b0;
    check("st_done_busy", {15'b0, busy_store}, 16'h0000);
    check("st_done_rom_addr", bus.rom_addr, 16'h0010);

    // reset in the middle of a STORE
    bus.rom_ack = 1'b1; bus.rom_data = 16'h8000;
    tick();
    bus.rom_ack = 1'b0; dref_a = 1'b1; dat_r = 16'h5555;
    tick();
    dref_a = 1'b0;
    check("rs_in_store", {15'b0, bus.ram_req}, 16'h0001);
    rst = 1'b1; bus.ram_ack = 1'b1;
    #1;
    check("rs_ram_req_now", {15'b0, bus.ram_req}, 16'h0000);
    check("rs_ram_we_now", {15'b0, bus.ram_we}, 16'h0000);
    tick();
    rst = 1'b0;
    #1;
    check("rs_pc", dbg_pc, 16'h0000);
    check("rs_fetch", {15'b0, bus.rom_req}, 16'h0001);
    check("rs_not_store", {15'b0, busy_store}, 16'h0000);
    tick();
    bus.ram_ack = 1'b0;
    check("rs_store_count", n_stores[15:0], 16'h0001);

    // PC wrap on the FFFF-reset instance
    tick();
    rst2 = 1'b0;
    #1;
    check("wrap_reset_pc", dbg_pc2, 16'hFFFF);
    check("wrap_rom_addr", bus2.rom_addr, 16'hFFFF);
    bus2.rom_ack = 1'b1; bus2.rom_data = 16'h0005;
    tick();
    bus2.rom_ack = 1'b0;
    check("wrap_pc", dbg_pc2, 16'h0000);
    check("wrap_a", dat_a2, 16'h0005);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
